// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among NREQ requesters,
//            with inter-frame gap and a timeout against a stuck transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int GAP_CYC = 16,
    parameter int TO_CYC  = 2000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DBIT-1:0]     i_data,
    input  logic                     i_done_tx,
    output logic                     o_tx_start,
    output logic [DBIT-1:0]          o_tx_data,
    output logic [NREQ-1:0]          o_ack,
    output logic [NREQ-1:0]          o_done,
    output logic                     o_err,
    output logic                     o_busy,
    output logic [$clog2(NREQ)-1:0]  o_grant_id
);

    localparam int IDW  = $clog2(NREQ);
    localparam int TOW  = $clog2(TO_CYC + 1);
    localparam int GW   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [IDW-1:0]   grant_id_d;
    logic [DBIT-1:0]  tx_data_d;
    logic [NREQ-1:0]  ack_d, done_d;
    logic             tx_start_d, err_d, busy_d;
    logic [TOW-1:0]   to_cnt, to_cnt_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;

    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW:0]     cand_w;
    logic [IDW-1:0]   cand;

    // Search starts just past the last grant, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_w    = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_w = {1'b0, ptr} + (IDW+1)'(i);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            cand = cand_w[IDW-1:0];
            if (!sel_found && i_req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        grant_id_d = o_grant_id;
        tx_data_d  = o_tx_data;
        ack_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = to_cnt;
        gap_cnt_d  = gap_cnt;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    tx_data_d  = i_data[sel_idx*DBIT +: DBIT];
                    grant_id_d = sel_idx;
                    ptr_d      = sel_idx;
                    ack_d      = NREQ'(1) << sel_idx;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (i_done_tx) begin
                    done_d    = NREQ'(1) << o_grant_id;
                    gap_cnt_d = GW'(GAP_CYC);
                    state_d   = GAP;
                end else if (to_cnt == TOW'(TO_CYC - 1)) begin
                    err_d     = 1'b1;
                    gap_cnt_d = GW'(GAP_CYC);
                    state_d   = GAP;
                end else begin
                    to_cnt_d  = to_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            o_grant_id <= '0;
            o_tx_data  <= '0;
            o_ack      <= '0;
            o_done     <= '0;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            o_grant_id <= grant_id_d;
            o_tx_data  <= tx_data_d;
            o_ack      <= ack_d;
            o_done     <= done_d;
            o_tx_start <= tx_start_d;
            o_err      <= err_d;
            o_busy     <= busy_d;
            to_cnt     <= to_cnt_d;
            gap_cnt    <= gap_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (NREQ=4, GAP=2, TO=50).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DBIT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DBIT-1:0] data = '0;
    logic                 done_tx = 1'b0;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_data;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 busy;
    logic [1:0]           grant_id;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DBIT(DBIT), .GAP_CYC(2), .TO_CYC(50)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .i_done_tx(done_tx), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_ack(ack), .o_done(done), .o_err(err), .o_busy(busy),
        .o_grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output logic [7:0] d, output logic [1:0] id, output int cnt);
        bit found = 0;
        cnt = 0;
        d   = '0;
        id  = '0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (tx_start) begin
                found = 1;
                cnt   = i;
                d     = tx_data;
                id    = grant_id;
                break;
            end
        end
        if (!found) check("start_timeout", 0, 1);
    endtask

    task automatic pulse_done();
        done_tx = 1'b1;
        step();
        done_tx = 1'b0;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        step();
        step();
        #3 rst_n = 1'b1;
        step();
    endtask

    logic [7:0] d;
    logic [1:0] id;
    int         cnt;
    int         seen_err;
    logic [7:0] exp_d [5];
    logic [1:0] exp_id[5];

    initial begin
        data = {8'h44, 8'h33, 8'h22, 8'hA5};
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_outs", {tx_start, ack, done, err, grant_id}, 0);
        check("rst_data", tx_data, 0);

        // Single request, exact pulse timing
        req = 4'b0001;
        step();
        check("t1_ack", ack, 4'b0001);
        check("t1_start_early", tx_start, 0);
        req = 4'b0000;
        step();
        check("t1_ack_drop", ack, 0);
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'hA5);
        step();
        check("t1_start_once", tx_start, 0);
        step();
        pulse_done();
        check("t1_done", done, 4'b0001);
        step();
        check("t1_done_once", done, 0);
        check("t1_busy_gap", busy, 1);
        step();
        check("t1_busy_gap2", busy, 1);
        step();
        check("t1_busy_fall", busy, 0);

        // Fairness with all requesters busy
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b1111;
        exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) begin
            wait_start(d, id, cnt);
            check($sformatf("rr_data%0d", k), d, exp_d[k]);
            check($sformatf("rr_id%0d", k), id, exp_id[k]);
            if (k == 4) req = 4'b0000;
            step();
            pulse_done();
        end

        // Wrap-around after a grant to 2
        req = 4'b0100;
        wait_start(d, id, cnt);
        check("wr_id_first", id, 2);
        req = 4'b1011;
        pulse_done();
        exp_d[0] = 8'h44; exp_d[1] = 8'h11; exp_d[2] = 8'h22;
        exp_id[0] = 2'd3; exp_id[1] = 2'd0; exp_id[2] = 2'd1;
        for (int k = 0; k < 3; k++) begin
            wait_start(d, id, cnt);
            check($sformatf("wr_id%0d", k), id, exp_id[k]);
            check($sformatf("wr_data%0d", k), d, exp_d[k]);
            if (k == 2) req = 4'b0000;
            pulse_done();
        end

        // Timeout with a pending requester
        req = 4'b0101;
        wait_start(d, id, cnt);
        check("to_id", id, 2);
        req = 4'b0001;
        seen_err = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (err || done != 0) seen_err++;
        end
        check("to_no_early_err", seen_err, 0);
        step();
        check("to_err", err, 1);
        check("to_no_done", done, 0);
        wait_start(d, id, cnt);
        check("to_next_id", id, 0);
        check("to_next_lat", cnt, 5);
        req = 4'b0000;
        pulse_done();

        // Done coinciding with timeout, then stray done in IDLE
        req = 4'b0010;
        wait_start(d, id, cnt);
        check("dt_id", id, 1);
        req = 4'b0000;
        for (int i = 0; i < 49; i++) step();
        pulse_done();
        check("dt_done", done, 4'b0010);
        check("dt_no_err", err, 0);
        step(); step(); step();
        check("dt_idle", busy, 0);
        pulse_done();
        check("stray_done", done, 0);
        seen_err = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tx_start || busy) seen_err++;
        end
        check("stray_no_start", seen_err, 0);
        req = 4'b0010;
        wait_start(d, id, cnt);
        req = 4'b0000;
        seen_err = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done != 0 || err) seen_err++;
        end
        check("stray_not_kept", seen_err, 0);
        pulse_done();

        // Asynchronous reset mid-WAIT
        req = 4'b1000;
        wait_start(d, id, cnt);
        check("ar_id", id, 3);
        step();
        #3 rst_n = 1'b0;
        #1;
        check("ar_outs", {tx_start, ack, done, err, busy, grant_id}, 0);
        check("ar_data", tx_data, 0);
        req = 4'b1001;
        #1 rst_n = 1'b1;
        wait_start(d, id, cnt);
        check("ar_prio_id", id, 0);
        check("ar_prio_data", d, 8'h11);
        req = 4'b0000;
        pulse_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
